// File: rtl/midpoint_circle_gen.sv
// Midpoint (Bresenham) circle generator: streams the 8 octant points of every
// iteration for a latched centre/radius over a valid/ready output port.
module midpoint_circle_gen #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned RAD_W   = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [RAD_W-1:0]   radius,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [COORD_W-1:0] pt_x,
    output logic [COORD_W-1:0] pt_y,
    output logic [2:0]         pt_oct,
    output logic               busy,
    output logic               done
);

    localparam int unsigned XY_W  = RAD_W + 1;
    localparam int unsigned ERR_W = RAD_W + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_STEP,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic signed [XY_W-1:0]    x_q, x_d;
    logic signed [XY_W-1:0]    y_q, y_d;
    logic signed [ERR_W-1:0]   err_q, err_d;
    logic [2:0]                oct_q, oct_d;
    logic [COORD_W-1:0]        cx_q, cx_d;
    logic [COORD_W-1:0]        cy_q, cy_d;
    logic                      pt_valid_q, pt_valid_d;
    logic [COORD_W-1:0]        pt_x_q, pt_x_d;
    logic [COORD_W-1:0]        pt_y_q, pt_y_d;
    logic [2:0]                pt_oct_q, pt_oct_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic signed [XY_W-1:0]    x_n, y_n;
    logic signed [ERR_W-1:0]   x_n_e, y_n_e;
    logic [COORD_W-1:0]        x_c, y_c;
    logic [COORD_W-1:0]        px, py;

    // Next-state, iteration update and registered-output preparation
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        err_d      = err_q;
        oct_d      = oct_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        pt_x_d     = pt_x_q;
        pt_y_d     = pt_y_q;
        pt_oct_d   = pt_oct_q;
        x_n        = x_q - XY_W'(1);
        y_n        = y_q + XY_W'(1);
        x_n_e      = ERR_W'(x_n);
        y_n_e      = ERR_W'(y_n);
        x_c        = '0;
        y_c        = '0;
        px         = '0;
        py         = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cx_d    = cx;
                    cy_d    = cy;
                    x_d     = XY_W'(radius);
                    y_d     = '0;
                    err_d   = ERR_W'(1) - ERR_W'(radius);
                    oct_d   = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (pt_ready) begin
                    if (oct_q == 3'd7) begin
                        state_d = S_STEP;
                    end else begin
                        oct_d = oct_q + 3'd1;
                    end
                end
            end
            S_STEP: begin
                y_d = y_n;
                if (err_q[ERR_W-1]) begin
                    err_d = err_q + (y_n_e <<< 1) + ERR_W'(1);
                end else begin
                    x_d   = x_n;
                    err_d = err_q + ((y_n_e - x_n_e) <<< 1) + ERR_W'(1);
                end
                if (x_d >= y_d) begin
                    oct_d   = '0;
                    state_d = S_EMIT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Octant mirror of the next point; x/y are non-negative while emitting
        x_c = COORD_W'($unsigned(x_d));
        y_c = COORD_W'($unsigned(y_d));
        unique case (oct_d)
            3'd0: begin px = cx_d + x_c; py = cy_d + y_c; end
            3'd1: begin px = cx_d + y_c; py = cy_d + x_c; end
            3'd2: begin px = cx_d - y_c; py = cy_d + x_c; end
            3'd3: begin px = cx_d - x_c; py = cy_d + y_c; end
            3'd4: begin px = cx_d - x_c; py = cy_d - y_c; end
            3'd5: begin px = cx_d - y_c; py = cy_d - x_c; end
            3'd6: begin px = cx_d + y_c; py = cy_d - x_c; end
            default: begin px = cx_d + x_c; py = cy_d - y_c; end
        endcase

        pt_valid_d = (state_d == S_EMIT);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        if (pt_valid_d) begin
            pt_x_d   = px;
            pt_y_d   = py;
            pt_oct_d = oct_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            err_q      <= '0;
            oct_q      <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            pt_valid_q <= 1'b0;
            pt_x_q     <= '0;
            pt_y_q     <= '0;
            pt_oct_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            err_q      <= err_d;
            oct_q      <= oct_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            pt_valid_q <= pt_valid_d;
            pt_x_q     <= pt_x_d;
            pt_y_q     <= pt_y_d;
            pt_oct_q   <= pt_oct_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign pt_valid = pt_valid_q;
    assign pt_x     = pt_x_q;
    assign pt_y     = pt_y_q;
    assign pt_oct   = pt_oct_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_midpoint_circle_gen.sv
// Scoreboard bench for midpoint_circle_gen: directed circles, wrap, stalls, reset abort.
module tb_midpoint_circle_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] radius;
    logic [9:0] cx, cy;
    logic       pt_valid;
    logic       pt_ready;
    logic [9:0] pt_x, pt_y;
    logic [2:0] pt_oct;
    logic       busy, done;

    midpoint_circle_gen #(.COORD_W(10), .RAD_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .radius(radius),
        .cx(cx), .cy(cy), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_x(pt_x), .pt_y(pt_y), .pt_oct(pt_oct), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] oct;
    } pt_t;

    pt_t sb[$];
    int  errors    = 0;
    int  checks    = 0;
    int  done_cnt  = 0;
    int  acc_cnt   = 0;
    bit  rand_mode = 1'b0;
    bit  band_chk  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push_pt(input int x, input int y, input int oct);
        pt_t p;
        p.x   = 10'(x);
        p.y   = 10'(y);
        p.oct = 3'(oct);
        sb.push_back(p);
    endfunction

    // Eight octant points of one iteration, modulo 1024
    function automatic void push8(input int x, input int y, input int ccx, input int ccy);
        push_pt(ccx + x, ccy + y, 0);
        push_pt(ccx + y, ccy + x, 1);
        push_pt(ccx - y, ccy + x, 2);
        push_pt(ccx - x, ccy + y, 3);
        push_pt(ccx - x, ccy - y, 4);
        push_pt(ccx - y, ccy - x, 5);
        push_pt(ccx + y, ccy - x, 6);
        push_pt(ccx + x, ccy - y, 7);
    endfunction

    function automatic void push_r5(input int ccx, input int ccy);
        push8(5, 0, ccx, ccy);
        push8(5, 1, ccx, ccy);
        push8(5, 2, ccx, ccy);
        push8(4, 3, ccx, ccy);
    endfunction

    // Ready driver
    always @(posedge clk) begin
        #1;
        pt_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: scoreboard pops, stall stability, band check, done counting
    logic [9:0] hx, hy;
    logic [2:0] ho;
    bit         hold = 1'b0;
    always @(negedge clk) begin
        pt_t e;
        logic signed [9:0] dx, dy;
        int dsq;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (hold) begin
                checks++;
                if (!pt_valid || pt_x != hx || pt_y != hy || pt_oct != ho) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                             pt_valid, pt_x, pt_y, pt_oct, hx, hy, ho);
                end
            end
            hold = 1'b0;
            if (pt_valid) begin
                if (pt_ready) begin
                    checks++;
                    acc_cnt++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL extra_point: got (%0d,%0d,%0d) expected none", pt_x, pt_y, pt_oct);
                    end else begin
                        e = sb.pop_front();
                        if (pt_x != e.x || pt_y != e.y || pt_oct != e.oct) begin
                            errors++;
                            $display("FAIL point: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                                     pt_x, pt_y, pt_oct, e.x, e.y, e.oct);
                        end
                    end
                    if (band_chk) begin
                        dx  = signed'(pt_x - 10'd200);
                        dy  = signed'(pt_y - 10'd200);
                        dsq = int'(dx) * int'(dx) + int'(dy) * int'(dy);
                        checks++;
                        if (dsq < 20 || dsq > 34) begin
                            errors++;
                            $display("FAIL band: got r2=%0d expected 20..34", dsq);
                        end
                    end
                end else begin
                    hold = 1'b1;
                    hx = pt_x;
                    hy = pt_y;
                    ho = pt_oct;
                end
            end
        end
    end

    task automatic do_start(input int r, input int ccx, input int ccy);
        @(posedge clk);
        #1;
        radius = 7'(r);
        cx     = 10'(ccx);
        cy     = 10'(ccy);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget, input int d0);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_finished"}, int'(ok), 1);
        @(posedge clk);
        #1;
        chk({name, "_sb_drained"}, sb.size(), 0);
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        bit ok;
        rst_n = 1'b0; start = 1'b0; radius = '0; cx = '0; cy = '0; pt_ready = 1'b1;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 start = 1'b1; radius = 7'd3;
        @(posedge clk);
        #1;
        chk("rst_valid", int'(pt_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_xy", int'({pt_x, pt_y, pt_oct}), 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_valid", int'(pt_valid), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_xy", int'({pt_x, pt_y, pt_oct}), 0);

        // radius 1, hand-listed points and cycle timing
        push_pt(101, 50, 0); push_pt(100, 51, 1); push_pt(100, 51, 2); push_pt(99, 50, 3);
        push_pt(99, 50, 4);  push_pt(100, 49, 5); push_pt(100, 49, 6); push_pt(101, 50, 7);
        d0 = done_cnt;
        do_start(1, 100, 50);
        chk("r1_first_valid", int'(pt_valid), 1);
        chk("r1_busy", int'(busy), 1);
        repeat (9) @(posedge clk);
        #1;
        chk("r1_done_high", int'(done), 1);
        chk("r1_valid_low", int'(pt_valid), 0);
        @(posedge clk);
        #1;
        chk("r1_done_low", int'(done), 0);
        chk("r1_busy_low", int'(busy), 0);
        chk("r1_sb_drained", sb.size(), 0);
        chk("r1_done_pulses", done_cnt - d0, 1);

        // radius 5, band check
        band_chk = 1'b1;
        push_r5(200, 200);
        d0 = done_cnt;
        do_start(5, 200, 200);
        wait_idle("r5", 200, d0);
        band_chk = 1'b0;

        // Coordinate wrap
        push_r5(1022, 1);
        d0 = done_cnt;
        do_start(5, 1022, 1);
        wait_idle("wrap", 200, d0);

        // Backpressure plus ignored start during busy
        rand_mode = 1'b1;
        push_r5(200, 200);
        d0 = done_cnt;
        do_start(5, 200, 200);
        @(posedge clk);
        #1 start = 1'b1; radius = 7'd9; cx = 10'd5; cy = 10'd7;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("bp", 2000, d0);
        rand_mode = 1'b0;

        // Reset mid-run
        push_r5(200, 200);
        d0 = done_cnt;
        acc_cnt = 0;
        do_start(5, 200, 200);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt >= 10) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_reached_10", int'(ok), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid_async", int'(pt_valid), 0);
        chk("mid_busy_async", int'(busy), 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_done", done_cnt - d0, 0);
        rst_n = 1'b1;
        push_r5(200, 200);
        d0 = done_cnt;
        do_start(5, 200, 200);
        wait_idle("restart", 200, d0);

        // radius 0
        push8(0, 0, 300, 400);
        d0 = done_cnt;
        do_start(0, 300, 400);
        wait_idle("r0", 200, d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
